uart_rx: RTL and testbench

// - UART receiver for 8N1 serial frames (LSB first). Receive-side partner of the UART transmitter.
// - Synchronises the asynchronous RX pin and samples each bit at mid-bit.
// - Presents each received byte with a one-cycle valid strobe to the SmartWatch core logic.

---
 rtl/uart_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined).
//
// The asynchronous RX pin passes through a two-flop synchroniser. Each bit
// is then sampled once at mid-bit: the start bit is confirmed half a bit
// after its falling edge, and every later bit is taken one full bit period
// after the previous sample.
//
// Ports:
//   clk              system clock
//   rst              synchronous, active-high reset
//   i_RX_Serial      asynchronous serial line, idle high
//   o_RX_DV          one-cycle strobe: o_RX_Byte is valid
//   o_RX_Byte        last received byte, held until the next DV
//   o_RX_Active      high while a frame is being received
//   o_RX_Frame_Err   one-cycle strobe: stop bit sampled low
//   o_RX_Parity_Err  one-cycle strobe: even-parity mismatch
//                    (present only when UART_RX_PARITY_EN is defined)
//
// Optional feature macro: UART_RX_PARITY_EN
//   Inserts an even-parity bit between the data and the stop bit.
module uart_rx #(
  parameter int FPGA_clk_freq = 50000000,
  parameter int baudrate      = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
`ifdef UART_RX_PARITY_EN
  output logic       o_RX_Frame_Err,
  output logic       o_RX_Parity_Err
`else
  output logic       o_RX_Frame_Err
`endif
);

  localparam int CLKS_PER_BIT = FPGA_clk_freq / baudrate;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_CLEANUP
  } state_t;

  // Synchroniser flops reset high so a reset never looks like a start edge.
  logic             r_rx_meta;
  logic             r_rx_s;

  state_t           r_state,  w_state;
  logic [CNT_W-1:0] r_cnt,    w_cnt;
  logic [2:0]       r_idx,    w_idx;
  logic [7:0]       r_shift,  w_shift;
  logic [7:0]       w_byte;
  logic             w_dv;
  logic             w_active;
  logic             w_fe;
`ifdef UART_RX_PARITY_EN
  logic             r_par,    w_par;
  logic             w_pe;
  logic             w_par_bad;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_RX_Serial;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_shift        <= '0;
      o_RX_Byte      <= '0;
      o_RX_DV        <= 1'b0;
      o_RX_Active    <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par          <= 1'b0;
      o_RX_Parity_Err <= 1'b0;
`endif
    end else begin
      r_state        <= w_state;
      r_cnt          <= w_cnt;
      r_idx          <= w_idx;
      r_shift        <= w_shift;
      o_RX_Byte      <= w_byte;
      o_RX_DV        <= w_dv;
      o_RX_Active    <= w_active;
      o_RX_Frame_Err <= w_fe;
`ifdef UART_RX_PARITY_EN
      r_par          <= w_par;
      o_RX_Parity_Err <= w_pe;
`endif
    end
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_idx    = r_idx;
    w_shift  = r_shift;
    w_byte   = o_RX_Byte;
    w_active = o_RX_Active;
    // Strobes default low so each one lasts exactly one cycle.
    w_dv     = 1'b0;
    w_fe     = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par     = r_par;
    w_pe      = 1'b0;
    w_par_bad = ((^r_shift) != r_par);
`endif

    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        w_idx = '0;
        if (!r_rx_s) begin
          w_state  = S_START;
          w_active = 1'b1;
        end
      end

      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt = '0;
          if (!r_rx_s) begin
            w_state = S_DATA;
          end else begin
            // Line went back high before mid-bit: a glitch, not a frame.
            w_state  = S_IDLE;
            w_active = 1'b0;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt          = '0;
          w_shift[r_idx] = r_rx_s;
          if (r_idx == 3'd7) begin
            w_idx   = '0;
`ifdef UART_RX_PARITY_EN
            w_state = S_PARITY;
`else
            w_state = S_STOP;
`endif
          end else begin
            w_idx = r_idx + 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == FULL_M1) begin
          w_cnt   = '0;
          w_par   = r_rx_s;
          w_state = S_STOP;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt   = '0;
          w_state = S_CLEANUP;
          w_fe    = !r_rx_s;
`ifdef UART_RX_PARITY_EN
          w_pe = w_par_bad;
          if (r_rx_s && !w_par_bad) begin
            w_dv   = 1'b1;
            w_byte = r_shift;
          end
`else
          if (r_rx_s) begin
            w_dv   = 1'b1;
            w_byte = r_shift;
          end
`endif
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      // Leaving here at mid stop bit gives half a bit of slack before the
      // next start edge, so back-to-back frames are never missed.
      S_CLEANUP: begin
        w_active = 1'b0;
        w_state  = S_IDLE;
      end

      default: begin
        w_state  = S_IDLE;
        w_cnt    = '0;
        w_idx    = '0;
        w_active = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB  = 50000000 / 115200;  // 434
  localparam int HALF = CPB / 2;            // 217
`ifdef UART_RX_PARITY_EN
  localparam int LAT  = 2 + HALF + 10 * CPB;
`else
  localparam int LAT  = 2 + HALF + 9 * CPB;  // 4125
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       dv;
  logic [7:0] rbyte;
  logic       active;
  logic       fe;
`ifdef UART_RX_PARITY_EN
  logic       pe;
`endif

  uart_rx #(.FPGA_clk_freq(50000000), .baudrate(115200)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_RX_Serial    (rx),
    .o_RX_DV        (dv),
    .o_RX_Byte      (rbyte),
    .o_RX_Active    (active),
`ifdef UART_RX_PARITY_EN
    .o_RX_Frame_Err (fe),
    .o_RX_Parity_Err(pe)
`else
    .o_RX_Frame_Err (fe)
`endif
  );

  always #5 clk = ~clk;

  // Monotonic event counters, written only here; the test diffs snapshots.
  int         pcyc = 0;
  int         dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, act_cnt = 0, ovl_cnt = 0;
  int         dv_cyc = 0;
  logic [7:0] byte_hist [0:63];

  always @(posedge clk) pcyc <= pcyc + 1;

  always @(negedge clk) begin
    if (dv) begin
      byte_hist[dv_cnt & 63] = rbyte;
      if (dv_cnt == 0 || dv_cyc == 0) dv_cyc = pcyc;
      else dv_cyc = pcyc;
      dv_cnt = dv_cnt + 1;
    end
    if (fe) fe_cnt = fe_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (pe) pe_cnt = pe_cnt + 1;
`endif
    if (dv && fe) ovl_cnt = ovl_cnt + 1;
    if (active) act_cnt = act_cnt + 1;
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected in [%0d,%0d]", name, act, lo, hi);
    end
  endtask

  // Called on a negedge; returns on a negedge with the line idle high.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip_par);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ flip_par;
    repeat (CPB) @(negedge clk);
`else
    if (flip_par) rx = 1'b1;
`endif
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_dv;
    int         exp_fe;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vt [0:4];

  int d0, f0, p0, a0, t0;

  initial begin
    vt[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
    vt[1] = '{8'hA5, 1'b0, 0, 1, 8'h55};  // bad stop: byte holds 55
    vt[2] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vt[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vt[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_byte",   int'(rbyte),  0);
    check("rst_dv",     int'(dv),     0);
    check("rst_active", int'(active), 0);
    check("rst_fe",     int'(fe),     0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      d0 = dv_cnt; f0 = fe_cnt; a0 = act_cnt; t0 = pcyc;
      send_frame(vt[i].data, vt[i].stop, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      check($sformatf("vec%0d_dv", i),   dv_cnt - d0, vt[i].exp_dv);
      check($sformatf("vec%0d_fe", i),   fe_cnt - f0, vt[i].exp_fe);
      check($sformatf("vec%0d_byte", i), int'(rbyte), int'(vt[i].exp_byte));
      if (i == 0) begin
        check_rng("lat_55", dv_cyc - t0, LAT - 2, LAT + 2);
        check_rng("active_55", act_cnt - a0, LAT - 10, LAT + 10);
        check("active_idle", int'(active), 0);
      end
    end

    // Back-to-back 00 then FF, stop bit exactly one bit period
    d0 = dv_cnt; f0 = fe_cnt;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("b2b_dv", dv_cnt - d0, 2);
    check("b2b_fe", fe_cnt - f0, 0);
    check("b2b_first",  int'(byte_hist[d0 & 63]),       8'h00);
    check("b2b_second", int'(byte_hist[(d0 + 1) & 63]), 8'hFF);

    // 100-cycle low glitch on an idle line
    d0 = dv_cnt; f0 = fe_cnt; a0 = act_cnt;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_dv", dv_cnt - d0, 0);
    check("glitch_fe", fe_cnt - f0, 0);
    check_rng("glitch_active", act_cnt - a0, HALF - 5, HALF + 5);
    check("glitch_byte", int'(rbyte), 8'hFF);

    // Reset in the middle of data bit 4 of 3C, then a clean C3
    d0 = dv_cnt; f0 = fe_cnt;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h3C >> i) & 1;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;  // bit 4 of 3C is 1
    repeat (HALF) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_active", int'(active), 0);
    check("midrst_byte",   int'(rbyte),  0);
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("midrst_dv",   dv_cnt - d0, 1);
    check("midrst_fe",   fe_cnt - f0, 0);
    check("midrst_rbyte", int'(rbyte), 8'hC3);

`ifdef UART_RX_PARITY_EN
    // 07 has odd weight, so the even-parity bit must be 1
    d0 = dv_cnt; p0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check("par_bad_dv", dv_cnt - d0, 0);
    check("par_bad_pe", pe_cnt - p0, 1);
    d0 = dv_cnt; p0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("par_ok_dv",   dv_cnt - d0, 1);
    check("par_ok_pe",   pe_cnt - p0, 0);
    check("par_ok_byte", int'(rbyte), 8'h07);
`endif

    check("dv_fe_overlap", ovl_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
